// File: rtl/ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// ram_arb_pkg
//   Shared definitions for the two-master RAM arbiter:
//     - state_e      : arbiter FSM states (IDLE, ACCESS, RESP)
//     - M0 / M1      : master ids (M0 = instruction fetch, M1 = load/store)
//     - DEPTH_DEF / IDX_W_DEF : default RAM geometry
//     - word_index() : byte address -> zero-extended RAM word index
//     - addr_is_bad(): misaligned / out-of-range detection, only present when
//                      RAM_ARB_ERR_EN is defined
// ----------------------------------------------------------------------------
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int IDX_W_DEF = 8;
    localparam int DEPTH_DEF = 1 << IDX_W_DEF;

    // Drops the byte offset and keeps idx_w index bits, so the result wraps
    // modulo the RAM depth.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input int unsigned idx_w);
        return (byte_addr >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

`ifdef RAM_ARB_ERR_EN
    // Misaligned, or any address bit above the word index set.
    function automatic logic addr_is_bad(input logic [31:0] byte_addr,
                                         input int unsigned idx_w);
        return (byte_addr[1:0] != 2'b00) || ((byte_addr >> (idx_w + 2)) != 32'd0);
    endfunction
`endif

endpackage

// File: rtl/ram_arb_rr2.sv
// ----------------------------------------------------------------------------
// ram_arb_rr2
//   Combinational 2-way round-robin pick. The last-served pointer register
//   lives in the parent; this block only decides.
//   Ports:
//     req0_i, req1_i : requests from M0 / M1
//     last_i         : id of the master served most recently
//     gnt_o[1:0]     : one-hot pick (bit0 = M0, bit1 = M1), 0 when no request
// ----------------------------------------------------------------------------
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        gnt_o = 2'b00;
        if (req0_i && req1_i) begin
            // Tie: the master that was not served last wins.
            gnt_o = (last_i == M1) ? 2'b01 : 2'b10;
        end else begin
            gnt_o = {req1_i, req0_i};
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//   Shares one single-port SoC data RAM between M0 (instruction fetch) and
//   M1 (load/store). One access at a time: IDLE -> ACCESS (one cycle, RAM
//   strobed) -> RESP (held until the owner's RREADY).
//
//   Configuration macro: RAM_ARB_ERR_EN
//     defined   : misaligned or out-of-range addresses get an ERR response
//                 and never touch the RAM.
//     undefined : oMx_ERR tied low, address wraps modulo DEPTH.
//
//   Ports:
//     iARB_CLK, iARB_RSTN           clock, async active-low reset
//     iMx_REQ/WE/WSTRB/ADDR/WDATA   request channel of master x
//     oMx_GNT                       request accepted this cycle (IDLE only)
//     oMx_RVALID/RDATA/ERR, iMx_RREADY  response channel of master x
//     oRAM_CE/RD/WR/WSTRB/RADDR/WADDR/WDATA, iRAM_RDATA  RAM macro side
//     oARB_BUSY                     high whenever not IDLE
// ----------------------------------------------------------------------------
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                iARB_CLK,
    input  logic                iARB_RSTN,

    input  logic                iM0_REQ,
    input  logic                iM0_WE,
    input  logic [DATA_W/8-1:0] iM0_WSTRB,
    input  logic [31:0]         iM0_ADDR,
    input  logic [DATA_W-1:0]   iM0_WDATA,
    output logic                oM0_GNT,
    output logic                oM0_RVALID,
    input  logic                iM0_RREADY,
    output logic [DATA_W-1:0]   oM0_RDATA,
    output logic                oM0_ERR,

    input  logic                iM1_REQ,
    input  logic                iM1_WE,
    input  logic [DATA_W/8-1:0] iM1_WSTRB,
    input  logic [31:0]         iM1_ADDR,
    input  logic [DATA_W-1:0]   iM1_WDATA,
    output logic                oM1_GNT,
    output logic                oM1_RVALID,
    input  logic                iM1_RREADY,
    output logic [DATA_W-1:0]   oM1_RDATA,
    output logic                oM1_ERR,

    output logic                oRAM_CE,
    output logic                oRAM_RD,
    output logic                oRAM_WR,
    output logic [DATA_W/8-1:0] oRAM_WSTRB,
    output logic [31:0]         oRAM_RADDR,
    output logic [31:0]         oRAM_WADDR,
    output logic [DATA_W-1:0]   oRAM_WDATA,
    input  logic [DATA_W-1:0]   iRAM_RDATA,

    output logic                oARB_BUSY
);

    // ------------------------------------------------------------------
    // State and captured transfer
    // ------------------------------------------------------------------
    state_e                state_q;
    logic                  owner_q;   // master that owns the current access
    logic                  last_q;    // last-served pointer for round robin
    logic                  we_q;
    logic                  bad_q;     // captured error flag (0 without ERR_EN)
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [31:0]           idx_q;     // zero-extended word index
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     rdata_q;   // response data held through RESP

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [1:0]            pick;
    logic [1:0]            gnt;
    logic                  sel;       // 1 selects M1's request fields
    logic                  sel_we;
    logic [DATA_W/8-1:0]   sel_wstrb;
    logic [31:0]           sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic                  sel_bad;
    logic                  owner_rready;
    logic                  in_resp;
    logic                  ram_en;

    ram_arb_rr2 u_rr2 (
        .req0_i (iM0_REQ),
        .req1_i (iM1_REQ),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    // Grants only exist in IDLE; gating with the reset keeps GNT low while
    // reset is held even though the state already reads IDLE.
    assign gnt = (state_q == IDLE && iARB_RSTN) ? pick : 2'b00;

    assign sel       = gnt[1];
    assign sel_we    = sel ? iM1_WE    : iM0_WE;
    assign sel_wstrb = sel ? iM1_WSTRB : iM0_WSTRB;
    assign sel_addr  = sel ? iM1_ADDR  : iM0_ADDR;
    assign sel_wdata = sel ? iM1_WDATA : iM0_WDATA;

`ifdef RAM_ARB_ERR_EN
    assign sel_bad = addr_is_bad(sel_addr, IDX_W);
`else
    assign sel_bad = 1'b0;
`endif

    assign owner_rready = (owner_q == M1) ? iM1_RREADY : iM0_RREADY;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge iARB_CLK or negedge iARB_RSTN) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!iARB_RSTN) begin
            state_q <= IDLE;
            owner_q <= M0;
            last_q  <= M1;           // M0 wins the first tie after reset
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            wstrb_q <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        owner_q <= sel;
                        last_q  <= sel;
                        we_q    <= sel_we;
                        bad_q   <= sel_bad;
                        wstrb_q <= sel_wstrb;
                        idx_q   <= word_index(sel_addr, IDX_W);
                        wdata_q <= sel_wdata;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Writes and error responses return zero data.
                    rdata_q <= (we_q || bad_q) ? '0 : iRAM_RDATA;
                    state_q <= RESP;
                end
                RESP: begin
                    if (owner_rready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Master-side outputs
    // ------------------------------------------------------------------
    assign in_resp    = (state_q == RESP);

    assign oM0_GNT    = gnt[0];
    assign oM1_GNT    = gnt[1];
    assign oM0_RVALID = in_resp && (owner_q == M0);
    assign oM1_RVALID = in_resp && (owner_q == M1);
    assign oM0_RDATA  = oM0_RVALID ? rdata_q : '0;
    assign oM1_RDATA  = oM1_RVALID ? rdata_q : '0;

`ifdef RAM_ARB_ERR_EN
    assign oM0_ERR    = oM0_RVALID && bad_q;
    assign oM1_ERR    = oM1_RVALID && bad_q;
`else
    assign oM0_ERR    = 1'b0;
    assign oM1_ERR    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // RAM-side outputs: everything is zero outside a clean ACCESS cycle
    // ------------------------------------------------------------------
    assign ram_en     = (state_q == ACCESS) && !bad_q;

    assign oRAM_CE    = ram_en;
    assign oRAM_RD    = ram_en && !we_q;
    assign oRAM_WR    = ram_en && we_q;
    assign oRAM_RADDR = oRAM_RD ? idx_q   : '0;
    assign oRAM_WADDR = oRAM_WR ? idx_q   : '0;
    assign oRAM_WSTRB = oRAM_WR ? wstrb_q : '0;
    assign oRAM_WDATA = oRAM_WR ? wdata_q : '0;

    assign oARB_BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter
//   Self-checking bench for ram_arbiter. A simple RAM macro model sits on the
//   RAM port; a separate reference memory tracks what the RAM should contain
//   from the accesses the bench issues, and supplies expected read data.
// ----------------------------------------------------------------------------
module tb_ram_arbiter;

    localparam int DEPTH = 256;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // Master-side stimulus
    logic [1:0]  req    = 2'b00;
    logic [1:0]  we     = 2'b00;
    logic [1:0]  rready = 2'b00;
    logic [3:0]  wstrb [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];

    // DUT outputs
    wire  [1:0]  gnt, rvalid, err;
    wire  [31:0] rdata0, rdata1;
    wire         ram_ce, ram_rd, ram_wr, busy;
    wire  [3:0]  ram_wstrb;
    wire  [31:0] ram_raddr, ram_waddr, ram_wdata;
    logic [31:0] ram_rdata;

    wire  [173:0] all_outs = {gnt, rvalid, err, rdata0, rdata1, ram_ce, ram_rd, ram_wr,
                              ram_wstrb, ram_raddr, ram_waddr, ram_wdata, busy};

    logic [31:0] mem     [DEPTH];   // RAM macro contents
    logic [31:0] ref_mem [DEPTH];   // expected contents

    int checks = 0;
    int errors = 0;

    // RAM macro: combinational read, byte-enabled write on the clock edge.
    assign ram_rdata = mem[ram_raddr[7:0]];
    always @(posedge clk) begin
        if (ram_wr) begin
            for (int b = 0; b < 4; b++)
                if (ram_wstrb[b]) mem[ram_waddr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    ram_arbiter dut (
        .iARB_CLK   (clk),
        .iARB_RSTN  (rstn),
        .iM0_REQ    (req[0]),
        .iM0_WE     (we[0]),
        .iM0_WSTRB  (wstrb[0]),
        .iM0_ADDR   (addr[0]),
        .iM0_WDATA  (wdata[0]),
        .oM0_GNT    (gnt[0]),
        .oM0_RVALID (rvalid[0]),
        .iM0_RREADY (rready[0]),
        .oM0_RDATA  (rdata0),
        .oM0_ERR    (err[0]),
        .iM1_REQ    (req[1]),
        .iM1_WE     (we[1]),
        .iM1_WSTRB  (wstrb[1]),
        .iM1_ADDR   (addr[1]),
        .iM1_WDATA  (wdata[1]),
        .oM1_GNT    (gnt[1]),
        .oM1_RVALID (rvalid[1]),
        .iM1_RREADY (rready[1]),
        .oM1_RDATA  (rdata1),
        .oM1_ERR    (err[1]),
        .oRAM_CE    (ram_ce),
        .oRAM_RD    (ram_rd),
        .oRAM_WR    (ram_wr),
        .oRAM_WSTRB (ram_wstrb),
        .oRAM_RADDR (ram_raddr),
        .oRAM_WADDR (ram_waddr),
        .oRAM_WDATA (ram_wdata),
        .iRAM_RDATA (ram_rdata),
        .oARB_BUSY  (busy)
    );

    // ------------------------------------------------------------------
    // Reference rules
    // ------------------------------------------------------------------
    function automatic logic [31:0] exp_idx(input logic [31:0] a);
        return 32'((a / 4) % DEPTH);
    endfunction

    function automatic logic exp_err(input logic [31:0] a);
`ifdef RAM_ARB_ERR_EN
        return (a % 4 != 0) || (a / 4 >= DEPTH);
`else
        return 1'b0 & a[0];
`endif
    endfunction

    // One complete transaction from master m, with all phases checked.
    // hold      : cycles RREADY stays low once the response is up
    // other_req : raise the other master's request right after acceptance
    task automatic do_txn(input int m, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, input int hold,
                          input logic other_req, input string nm,
                          output logic [31:0] rd_obs);
        int          o = 1 - m;
        int          n = 0;
        logic [31:0] idx_e, rd_e;
        logic        err_e;
        idx_e = exp_idx(a);
        err_e = exp_err(a);
        rd_e  = (w || err_e) ? 32'd0 : ref_mem[idx_e];
        rd_obs = 32'd0;

        we[m] = w; addr[m] = a; wdata[m] = d; wstrb[m] = s;
        rready[m] = (hold == 0); req[m] = 1'b1;
        #1;
        while (!gnt[m] && n < 50) begin @(posedge clk); #2; n++; end
        checks++;
        if (gnt[m] !== 1'b1) begin
            errors++; $display("FAIL %s grant timeout gnt=%b", nm, gnt);
            req[m] = 1'b0; return;
        end
        checks++;
        if (gnt[o] !== 1'b0) begin errors++; $display("FAIL %s double grant gnt=%b", nm, gnt); end

        @(posedge clk); #1;
        req[m] = 1'b0;
        if (other_req) begin req[o] = 1'b1; we[o] = 1'b0; addr[o] = 32'd0; end
        #1;
        // ACCESS cycle
        checks++;
        if ({ram_ce, ram_rd, ram_wr} !== {~err_e, ~w & ~err_e, w & ~err_e}) begin
            errors++; $display("FAIL %s access ctrl ce/rd/wr=%b%b%b exp %b%b%b", nm, ram_ce, ram_rd,
                               ram_wr, ~err_e, ~w & ~err_e, w & ~err_e);
        end
        checks++;
        if (ram_raddr !== ((!w && !err_e) ? idx_e : 32'd0)) begin
            errors++; $display("FAIL %s raddr got %h exp %h", nm, ram_raddr, idx_e);
        end
        checks++;
        if ({ram_waddr, ram_wstrb, ram_wdata} !== ((w && !err_e) ? {idx_e, s, d} : 68'd0)) begin
            errors++; $display("FAIL %s write port got %h/%b/%h exp %h/%b/%h", nm, ram_waddr,
                               ram_wstrb, ram_wdata, idx_e, s, d);
        end
        checks++;
        if (rvalid !== 2'b00 || gnt !== 2'b00 || busy !== 1'b1) begin
            errors++; $display("FAIL %s access state rvalid=%b gnt=%b busy=%b", nm, rvalid, gnt, busy);
        end
        if (w && !err_e)
            for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx_e][8*b +: 8] = d[8*b +: 8];

        @(posedge clk); #2;
        // RESP cycle
        rd_obs = (m == 0) ? rdata0 : rdata1;
        checks++;
        if (rvalid[m] !== 1'b1 || rd_obs !== rd_e || err[m] !== err_e) begin
            errors++; $display("FAIL %s resp rvalid=%b rdata=%h err=%b exp 1/%h/%b", nm, rvalid[m],
                               rd_obs, err[m], rd_e, err_e);
        end
        checks++;
        if (rvalid[o] !== 1'b0 || ((o == 0) ? rdata0 : rdata1) !== 32'd0 || err[o] !== 1'b0 ||
            ram_ce !== 1'b0) begin
            errors++; $display("FAIL %s non-owner/ram in resp rvalid=%b err=%b ce=%b", nm, rvalid, err, ram_ce);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #2;
            checks++;
            if (rvalid[m] !== 1'b1 || ((m == 0) ? rdata0 : rdata1) !== rd_obs || gnt !== 2'b00) begin
                errors++; $display("FAIL %s hold %0d rvalid=%b rdata=%h gnt=%b exp 1/%h/00", nm, i,
                                   rvalid[m], (m == 0) ? rdata0 : rdata1, gnt, rd_obs);
            end
        end
        rready[m] = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (rvalid[m] !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s release rvalid=%b busy=%b exp 0/0", nm, rvalid[m], busy);
        end
        rready[m] = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rstn = 1'b0; req = 2'b11; rready = 2'b11;
        #3;
        checks++;
        if (all_outs !== '0) begin errors++; $display("FAIL reset outputs got %h exp 0", all_outs); end
        @(posedge clk); #1;
        rstn = 1'b1; req = 2'b00; rready = 2'b00;
        @(posedge clk); #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset idle busy=%b exp 0", busy); end
    endtask

    task automatic test_m0_read();
        logic [31:0] rd;
        mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        do_txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 1'b0, "m0_read", rd);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL m0_read data got %h exp deadbeef", rd); end
    endtask

    task automatic test_m1_write();
        logic [31:0] rd;
        mem[2] = 32'h11223344; ref_mem[2] = 32'h11223344;
        do_txn(1, 1'b1, 32'h0000_0008, 32'hAABBCCDD, 4'b0011, 0, 1'b0, "m1_write", rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL m1_write resp data got %h exp 0", rd); end
        do_txn(0, 1'b0, 32'h0000_0008, 32'h0, 4'hF, 0, 1'b0, "m1_write_rb", rd);
        checks++;
        if (rd !== 32'h1122CCDD) begin errors++; $display("FAIL m1_write readback got %h exp 1122ccdd", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        mem[7] = 32'hC0FFEE01; ref_mem[7] = 32'hC0FFEE01;
        do_txn(0, 1'b0, 32'h0000_001C, 32'h0, 4'hA, 5, 1'b1, "bp_m0", rd);
        checks++;
        if (rd !== 32'hC0FFEE01) begin errors++; $display("FAIL bp_m0 data got %h exp c0ffee01", rd); end
        checks++;
        if (gnt !== 2'b10) begin errors++; $display("FAIL bp_m1_after_handshake gnt=%b exp 10", gnt); end
        do_txn(1, 1'b0, 32'h0000_001C, 32'h0, 4'h0, 0, 1'b0, "bp_m1", rd);
    endtask

    task automatic test_round_robin();
        rstn = 1'b0; req = 2'b11; we = 2'b00; addr[0] = 32'h0; addr[1] = 32'h4; rready = 2'b11;
        @(posedge clk); #1; rstn = 1'b1; #1;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 10 && gnt == 2'b00; c++) begin
                @(posedge clk); #2;
                checks++;
                if (gnt === 2'b11) begin errors++; $display("FAIL rr_two_gnt gnt=%b", gnt); end
            end
            checks++;
            if (gnt !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL rr_order grant %0d gnt=%b exp %b", k, gnt,
                                   (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            @(posedge clk); #2;
        end
        req = 2'b00;
        repeat (3) @(posedge clk);
        #2; rready = 2'b00;
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd;
        int          n = 0;
        mem[5] = 32'h55AA55AA; ref_mem[5] = 32'h55AA55AA;
        we[0] = 1'b1; addr[0] = 32'h0000_0014; wdata[0] = 32'h12345678; wstrb[0] = 4'hF; req[0] = 1'b1;
        #1;
        while (!gnt[0] && n < 20) begin @(posedge clk); #2; n++; end
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
        #1;
        checks++;
        if (ram_wr !== 1'b1) begin errors++; $display("FAIL rst_mid write access wr=%b exp 1", ram_wr); end
        rstn = 1'b0; #1;
        checks++;
        if (all_outs !== '0) begin errors++; $display("FAIL rst_mid async outputs got %h exp 0", all_outs); end
        @(posedge clk); #1; rstn = 1'b1; #1;
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL rst_mid first tie gnt=%b exp 01", gnt); end
        req = 2'b00;
        @(posedge clk); #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid no accept busy=%b exp 0", busy); end
        do_txn(0, 1'b0, 32'h0000_0014, 32'h0, 4'h0, 0, 1'b0, "rst_mid_rb", rd);
        checks++;
        if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL rst_mid aborted write got %h exp 55aa55aa", rd); end
    endtask

    task automatic test_addr_wrap_err();
        logic [31:0] rd;
        mem[0] = 32'h0BADF00D; ref_mem[0] = 32'h0BADF00D;
        do_txn(1, 1'b0, 32'h0000_0402, 32'h0, 4'hF, 0, 1'b0, "m1_read_402", rd);
        checks++;
`ifdef RAM_ARB_ERR_EN
        if (rd !== 32'd0) begin errors++; $display("FAIL m1_read_402 err data got %h exp 0", rd); end
`else
        if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL m1_read_402 wrap got %h exp 0badf00d", rd); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] rd, a;
        for (int t = 0; t < 40; t++) begin
            case ($urandom % 4)
                0:       a = $urandom;                          // anything
                1:       a = {22'd0, 8'($urandom), 2'($urandom)}; // maybe misaligned
                default: a = {22'd0, 8'($urandom), 2'b00};        // aligned, in range
            endcase
            do_txn(int'($urandom % 2), 1'($urandom), a, $urandom, 4'($urandom),
                   int'($urandom % 3), 1'b0, "random", rd);
            repeat ($urandom % 3) begin @(posedge clk); #2; end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin wstrb[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0; end
        for (int i = 0; i < DEPTH; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
        test_reset();
        test_m0_read();
        test_m1_write();
        test_backpressure();
        test_round_robin();
        test_reset_mid_access();
        test_addr_wrap_err();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single SoC data RAM between two masters: M0 = instruction fetch, M1 = load/store unit.
- Per-master request/grant plus response handshake.
- Serialises one access at a time and drives the RAM's CE/RD/WR/WSTRB and word-address ports.
- Sits between the core's bus ports and the RAM macro.
- RAM read is combinational; RAM write commits on the clock edge.

Parameters:
- DATA_W, 32, data width. Fixed at 32: WSTRB is 4 bits.
- DEPTH, 256, RAM depth in 32-bit words.
- IDX_W, 8, word-index width; equals clog2(DEPTH).

Ports:
- iARB_CLK  in  1  clock
- iARB_RSTN  in  1  asynchronous active-low reset
- iM0_REQ / iM1_REQ  in  1  access request
- iM0_WE / iM1_WE  in  1  1=write, 0=read
- iM0_WSTRB / iM1_WSTRB  in  4  byte enables for writes
- iM0_ADDR / iM1_ADDR  in  32  byte address
- iM0_WDATA / iM1_WDATA  in  32  write data
- oM0_GNT / oM1_GNT  out  1  request accepted this cycle
- oM0_RVALID / oM1_RVALID  out  1  response valid
- iM0_RREADY / iM1_RREADY  in  1  master consumes response
- oM0_RDATA / oM1_RDATA  out  32  read data; 0 for writes
- oM0_ERR / oM1_ERR  out  1  error response; only with the optional feature
- oRAM_CE, oRAM_RD, oRAM_WR  out  1  RAM controls
- oRAM_WSTRB  out  4  RAM byte enables
- oRAM_RADDR, oRAM_WADDR  out  32  RAM word index, zero-extended
- oRAM_WDATA  out  32  RAM write data
- iRAM_RDATA  in  32  RAM read data
- oARB_BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset (iARB_RSTN=0, asynchronous):
  - state=IDLE, last-served pointer=M1 (so M0 wins the first tie).
  - All outputs 0; captured address, data, strobe and read-data registers cleared.
  - Reset mid-access aborts it: no response is issued and WR deasserts immediately.
- States:
  - IDLE: GNT is combinational. oMx_GNT=1 only if state==IDLE, iMx_REQ=1 and x is the arbitration winner. The transfer is accepted when REQ&&GNT; the arbiter latches WE/WSTRB/ADDR/WDATA and the master id, then goes to ACCESS.
  - ACCESS (exactly one cycle): oRAM_CE=1.
    - Read: oRAM_RD=1, oRAM_RADDR=ADDR[IDX_W+1:2]; iRAM_RDATA is captured at the cycle end.
    - Write: oRAM_WR=1, oRAM_WADDR=ADDR[IDX_W+1:2], oRAM_WSTRB and oRAM_WDATA driven; the RAM commits at the cycle end.
    - Next state: RESP.
  - RESP: the owning master sees RVALID=1 with RDATA held stable. RDATA is the captured data for reads and 0 for writes. On RVALID&&RREADY go to IDLE. Otherwise stay in RESP indefinitely; there is no timeout.
- Latency: accept in cycle N, RAM access in N+1, RVALID from N+2. A back-to-back new grant is possible at the earliest in N+3, since GNT is only given in IDLE.
- Arbitration: 2-way round-robin.
  - Both requesting: grant the master not in the last-served pointer.
  - One requesting: grant it regardless of the pointer.
  - The pointer updates only on acceptance.
- RAM control outputs are 0 in IDLE and RESP; no stray CE/RD/WR.
- The non-owning master sees RVALID=0 and RDATA=0.
- A master may drop REQ before GNT; this is legal and nothing is captured.
- Address [1:0] and bits above IDX_W+1 are ignored unless RAM_ARB_ERR_EN is defined.
- A read with WSTRB≠0 is legal; WSTRB is ignored.
- A write with WSTRB=0 performs no byte update and still gets a response.

Optional Feature:
- RAM_ARB_ERR_EN defined:
  - A request with ADDR[1:0]≠0, or with word index ≥ DEPTH (any of ADDR[31:IDX_W+2] set), is an error.
  - It is still granted and goes through ACCESS with CE/RD/WR all 0, so there is no RAM side effect.
  - It responds in RESP with ERR=1 and RDATA=0.
- RAM_ARB_ERR_EN undefined:
  - oMx_ERR tied 0.
  - Address wraps modulo DEPTH; low bits are ignored.

Decomposition:
- Shared package ram_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - master id constants M0=0, M1=1
  - DEPTH and IDX_W defaults
  - helper function for byte-address-to-word-index conversion
- Sub-module ram_arb_rr2: combinational 2-way round-robin pick from (req0, req1, last) giving a one-hot grant. The pointer register stays in the parent.

Test Plan:
- M0 only: read 0x0000_0010 while RAM word 4=0xDEADBEEF → GNT in cycle N; RD=1, RADDR=4 in N+1; oM0_RVALID=1, RDATA=0xDEADBEEF in N+2.
- M1 write 0x0000_0008, WDATA=0xAABBCCDD, WSTRB=0b0011 → WR=1, WADDR=2 in N+1; RAM word 2 low half=0xCCDD with upper bytes unchanged; oM1_RVALID with RDATA=0.
- Both REQ held continuously from reset → grants alternate M0, M1, M0, M1. Two GNTs are never asserted in the same cycle.
- RRDY backpressure: M0 read with RREADY=0 for 5 cycles → RVALID and RDATA stable; no GNT to the requesting M1 until the handshake completes.
- iARB_RSTN pulled low during ACCESS of a write → all outputs 0 asynchronously; after release, M0 wins the first tie.
- With RAM_ARB_ERR_EN: M1 read 0x0000_0402 → no CE pulse, ERR=1, RDATA=0. Without it: the same access reads word 0.
